mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter RAM_AW, default 10, meaning RAM word-address width (RAM depth 2^RAM_AW 32-bit words).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port i_req, input, 1, instruction-fetch request (read only).
REQ-005 The block SHALL have port i_addr, input, 32, instruction byte address.
REQ-006 The block SHALL have port i_gnt, output, 1, fetch accepted this cycle (combinational).
REQ-007 The block SHALL have ports i_rvalid, output, 1, and i_rdata, output, 32, the registered fetch response.
REQ-008 The block SHALL have ports d_req, input, 1; d_we, input, 1; d_addr, input, 32; d_funct3, input, 3; d_wdata, input, 32: data load/store request; funct3 uses RISC-V encoding.
REQ-009 The block SHALL have port d_gnt, output, 1, data request accepted this cycle (combinational).
REQ-010 The block SHALL have ports d_rvalid, output, 1; d_rdata, output, 32; d_err, output, 1: the registered data response.
REQ-011 The block SHALL have ports m_addr, output, RAM_AW; m_be, output, 4; m_wdata, output, 32; m_we, output, 1: drive one port of the synchronous byte-enable RAM.
REQ-012 The block SHALL have port m_rdata, input, 32, RAM read data, valid one cycle after the address is presented.

Function
REQ-013 Arbitration SHALL be round-robin: one requester active -> grant it; both active -> grant the one not granted most recently; at most one of i_gnt/d_gnt high per cycle.
REQ-014 Grants SHALL be issued back-to-back every cycle; a one-entry response register (valid, owner, funct3, byte offset, err) SHALL capture each grant for the next cycle.
REQ-015 m_addr SHALL equal the granted address bits [RAM_AW+1:2]; upper address bits SHALL be ignored (address wraps modulo RAM size).
REQ-016 m_we SHALL be 1 only for a granted, non-erroring data store; otherwise m_we=0 and m_be=0000.
REQ-017 Store byte enables: SB (000) -> 0001<<off; SH (001) -> 0011<<off; SW (010) -> 1111; off = d_addr[1:0].
REQ-018 Store data: SB -> byte replicated 4x; SH -> halfword replicated 2x; SW -> d_wdata unchanged.
REQ-019 Load extraction from m_rdata at the registered offset: LB (000) and LH (001) sign-extend; LW (010) full word; LBU (100) and LHU (101) zero-extend.
REQ-020 Misaligned access (halfword with off[0]=1, word with off!=00) or funct3 in {011,110,111} SHALL still be granted, but SHALL NOT write RAM, and SHALL respond next cycle with d_rvalid=1, d_err=1, d_rdata=0.
REQ-021 A granted store SHALL produce d_rvalid=1, d_err=0, d_rdata=0 in the following cycle.
REQ-022 A granted read SHALL produce exactly one rvalid pulse to its owner in the following cycle; rdata SHALL be 0 whenever rvalid=0.
REQ-023 A request not granted SHALL be held stable by the requester; the block does not queue requests.

Reset
REQ-024 While rst=1: i_gnt=d_gnt=0, i_rvalid=d_rvalid=d_err=0, rdata=0, m_we=0, m_be=0000, response register invalid; the round-robin pointer favours data on the first contention.
REQ-025 Asserting rst with a response in flight SHALL discard it; no rvalid SHALL appear after reset release for that grant.

Verification
REQ-026 Contention: i_req=d_req=1 for 4 cycles after reset -> grants d,i,d,i; each rvalid one cycle after its grant.
REQ-027 Store/load: SB 0xA5 to 0x101, then LB 0x101 -> m_be=0010, m_wdata=0xA5A5A5A5; d_rdata=0xFFFFFFA5; LBU 0x101 -> 0x000000A5.
REQ-028 Halfword: SH 0xBEEF to 0x002, then LW 0x000 -> m_be=1100 on the store; LW data[31:16]=0xBEEF, lower half unchanged.
REQ-029 Misalign: LW at 0x006 -> d_gnt=1, m_we=0, next cycle d_rvalid=1, d_err=1, d_rdata=0.
REQ-030 Reset mid-read: fetch granted at cycle N, rst pulsed at cycle N+1 -> i_rvalid stays 0 through and after reset.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the two requester channels (instruction fetch and
// data load/store) and the single RAM port handled by mem_arbiter.
//   slave  : arbiter view  (takes requests + RAM read data, drives grants,
//            responses and the RAM command)
//   master : environment view (requesters plus the RAM itself)
interface mem_arbiter_if #(
    parameter int RAM_AW = 10
);
    // instruction fetch channel
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    // data load/store channel
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [2:0]        d_funct3;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;
    // RAM port
    logic [RAM_AW-1:0] m_addr;
    logic [3:0]        m_be;
    logic [31:0]       m_wdata;
    logic              m_we;
    logic [31:0]       m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_funct3, d_wdata, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               m_addr, m_be, m_wdata, m_we
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_funct3, d_wdata, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               m_addr, m_be, m_wdata, m_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one synchronous byte-enable RAM
// port between an instruction-fetch requester and a data load/store requester.
// A grant is issued every cycle a request is present; the RAM answers one
// cycle later, when a one-entry response register routes (and for loads,
// extracts/extends) the read data to the owner of that grant.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mem_arbiter_if.slave: i_* fetch channel, d_* data channel
//          (funct3 in RISC-V encoding), m_* RAM port
module mem_arbiter #(
    parameter int RAM_AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    // ---------------- arbitration ----------------
    // last_d: 1 when data won the most recent grant. Reset value 0 makes data
    // the winner of the first contention.
    logic last_d;
    logic gnt_i, gnt_d;

    always_comb begin
        gnt_d = 1'b0;
        gnt_i = 1'b0;
        if (!rst) begin
            gnt_d = bus.d_req & (~bus.i_req | ~last_d);
            gnt_i = bus.i_req & ~gnt_d;
        end
    end

    assign bus.i_gnt = gnt_i;
    assign bus.d_gnt = gnt_d;

    // ---------------- data request decode ----------------
    logic [1:0]  off;
    logic        acc_err;
    logic [3:0]  st_be;
    logic [31:0] st_data;

    assign off = bus.d_addr[1:0];

    always_comb begin
        acc_err = 1'b0;
        case (bus.d_funct3)
            3'b000, 3'b100: acc_err = 1'b0;
            3'b001, 3'b101: acc_err = off[0];
            3'b010:         acc_err = (off != 2'b00);
            default:        acc_err = 1'b1;   // 011, 110, 111
        endcase
    end

    // Stores replicate the narrow datum across the word so the byte enables
    // alone select which lanes the RAM takes.
    always_comb begin
        st_be   = 4'b1111;
        st_data = bus.d_wdata;
        case (bus.d_funct3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << off;
                st_data = {4{bus.d_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = 4'b0011 << off;
                st_data = {2{bus.d_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = bus.d_wdata;
            end
        endcase
    end

    logic wr_en;
    assign wr_en       = gnt_d & bus.d_we & ~acc_err;
    assign bus.m_we    = wr_en;
    assign bus.m_be    = wr_en ? st_be : 4'b0000;
    assign bus.m_wdata = wr_en ? st_data : 32'h0;
    // Upper address bits are dropped: accesses wrap modulo the RAM size.
    assign bus.m_addr  = gnt_d ? bus.d_addr[RAM_AW+1:2] : bus.i_addr[RAM_AW+1:2];

    // ---------------- response register ----------------
    logic       rsp_vld;
    logic       rsp_d;      // owner: 1 = data, 0 = fetch
    logic [2:0] rsp_f3;
    logic [1:0] rsp_off;
    logic       rsp_err;
    logic       rsp_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d  <= 1'b0;
            rsp_vld <= 1'b0;
            rsp_d   <= 1'b0;
            rsp_f3  <= 3'b000;
            rsp_off <= 2'b00;
            rsp_err <= 1'b0;
            rsp_we  <= 1'b0;
        end else begin
            if (gnt_i | gnt_d)
                last_d <= gnt_d;
            rsp_vld <= gnt_i | gnt_d;
            rsp_d   <= gnt_d;
            rsp_f3  <= bus.d_funct3;
            rsp_off <= off;
            rsp_err <= gnt_d & acc_err;
            rsp_we  <= gnt_d & bus.d_we;
        end
    end

    // ---------------- load extraction ----------------
    logic [31:0] sh_word;
    logic [31:0] ld_data;

    assign sh_word = bus.m_rdata >> {rsp_off, 3'b000};

    always_comb begin
        ld_data = 32'h0;
        case (rsp_f3)
            3'b000:  ld_data = {{24{sh_word[7]}}, sh_word[7:0]};
            3'b001:  ld_data = {{16{sh_word[15]}}, sh_word[15:0]};
            3'b010:  ld_data = bus.m_rdata;
            3'b100:  ld_data = {24'h0, sh_word[7:0]};
            3'b101:  ld_data = {16'h0, sh_word[15:0]};
            default: ld_data = 32'h0;
        endcase
    end

    logic i_rv, d_rv;
    assign i_rv = rsp_vld & ~rsp_d;
    assign d_rv = rsp_vld & rsp_d;

    assign bus.i_rvalid = i_rv;
    assign bus.i_rdata  = i_rv ? bus.m_rdata : 32'h0;
    assign bus.d_rvalid = d_rv;
    assign bus.d_err    = d_rv & rsp_err;
    // Stores and faulting accesses answer with zero data.
    assign bus.d_rdata  = (d_rv & ~rsp_err & ~rsp_we) ? ld_data : 32'h0;

    logic unused;
    assign unused = ^{bus.i_addr[31:RAM_AW+2], bus.i_addr[1:0], bus.d_addr[31:RAM_AW+2]};

endmodule
